// File: rtl/isp_pkg.sv
// Shared ISP definitions: Bayer pattern codes, RGGB channel indices and
// counter-width helpers used by the raw-domain stages.
package isp_pkg;

   typedef enum logic [1:0] {
      BAYER_RGGB = 2'd0,
      BAYER_GRBG = 2'd1,
      BAYER_GBRG = 2'd2,
      BAYER_BGGR = 2'd3
   } bayer_e;

   typedef enum logic [1:0] {
      CH_R  = 2'd0,
      CH_GR = 2'd1,
      CH_GB = 2'd2,
      CH_B  = 2'd3
   } chan_e;

   // Width needed to hold a count of 0..n.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   // Width of an index 0..n-1, never below one bit.
   function automatic int pos_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/isp_raw_pos_cnt.sv
// Raster position of the current enabled pixel; advances only on en so that
// stream gaps leave the position untouched.
module isp_raw_pos_cnt
   import isp_pkg::*;
#(
   parameter int WIDTH  = 1936,
   parameter int HEIGHT = 1088
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   output logic [pos_w(WIDTH)-1:0]   h_cnt,
   output logic [pos_w(HEIGHT)-1:0]  v_cnt
);

   localparam int H_W = pos_w(WIDTH);
   localparam int V_W = pos_w(HEIGHT);

   logic h_end, v_end;

   assign h_end = (h_cnt == H_W'(WIDTH - 1));
   assign v_end = (v_cnt == V_W'(HEIGHT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (en) begin
         if (h_end) begin
            h_cnt <= '0;
            v_cnt <= v_end ? '0 : v_cnt + V_W'(1);
         end else begin
            h_cnt <= h_cnt + H_W'(1);
         end
      end
   end

endmodule

// File: rtl/isp_blc_norm.sv
// Black-level subtract, per-channel gain and round/saturate on a raw Bayer
// stream, with a per-frame count of pixels that fell below black.
module isp_blc_norm
   import isp_pkg::*;
#(
   parameter int BITS      = 8,
   parameter int WIDTH     = 1936,
   parameter int HEIGHT    = 1088,
   parameter int GAIN_W    = 12,
   parameter int GAIN_FRAC = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [BITS-1:0]                 black_r,
   input  logic [BITS-1:0]                 black_gr,
   input  logic [BITS-1:0]                 black_gb,
   input  logic [BITS-1:0]                 black_b,
   input  logic [GAIN_W-1:0]               gain_r,
   input  logic [GAIN_W-1:0]               gain_gr,
   input  logic [GAIN_W-1:0]               gain_gb,
   input  logic [GAIN_W-1:0]               gain_b,
   input  logic                            gain_en,
   input  logic [1:0]                      bayer,
   input  logic [BITS-1:0]                 per_raw_data,
   input  logic                            per_raw_data_en,
   output logic [BITS-1:0]                 post_raw_data,
   output logic                            post_raw_data_en,
   output logic [cnt_w(WIDTH*HEIGHT)-1:0]  under_cnt,
   output logic                            frame_done
);

   localparam int CNT_W = cnt_w(WIDTH * HEIGHT);
   localparam int P_W   = BITS + GAIN_W;
   localparam int H_W   = pos_w(WIDTH);
   localparam int V_W   = pos_w(HEIGHT);
   localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1) << GAIN_FRAC;
   localparam logic [P_W:0]      HALF  = (P_W + 1)'(1) << (GAIN_FRAC - 1);
   localparam logic [P_W:0]      MAXV  = (P_W + 1)'((1 << BITS) - 1);

   typedef struct packed {
      logic [BITS-1:0]   blk_r, blk_gr, blk_gb, blk_b;
      logic [GAIN_W-1:0] g_r, g_gr, g_gb, g_b;
      logic              gain_en;
      logic [1:0]        bayer;
   } cfg_t;

   logic [H_W-1:0]    h_cnt;
   logic [V_W-1:0]    v_cnt;
   logic              first, last;
   cfg_t              cfg_in, sh, cfg;
   chan_e             chan;
   logic [BITS-1:0]   blk;
   logic [GAIN_W-1:0] gsel, g_eff;
   logic              under;

   logic [3:1]        vld_pipe;
   logic [BITS-1:0]   s1_sub;
   logic [GAIN_W-1:0] s1_g;
   logic [P_W-1:0]    s2_prod;
   logic [P_W:0]      rnd, shifted;
   logic [BITS-1:0]   sat;
   logic [CNT_W-1:0]  acc;

   isp_raw_pos_cnt #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) u_pos (
      .clk   (clk),
      .rst   (rst),
      .en    (per_raw_data_en),
      .h_cnt (h_cnt),
      .v_cnt (v_cnt)
   );

   assign first = (h_cnt == '0) && (v_cnt == '0);
   assign last  = (h_cnt == H_W'(WIDTH - 1)) && (v_cnt == V_W'(HEIGHT - 1));

   assign cfg_in = '{blk_r: black_r, blk_gr: black_gr, blk_gb: black_gb, blk_b: black_b,
                     g_r: gain_r, g_gr: gain_gr, g_gb: gain_gb, g_b: gain_b,
                     gain_en: gain_en, bayer: bayer};

   // The (0,0) pixel already uses the values being latched on its own edge.
   assign cfg = first ? cfg_in : sh;

   always_ff @(posedge clk) begin
      if (rst) begin
         sh <= '{blk_r: '0, blk_gr: '0, blk_gb: '0, blk_b: '0,
                 g_r: UNITY, g_gr: UNITY, g_gb: UNITY, g_b: UNITY,
                 gain_en: 1'b0, bayer: BAYER_RGGB};
      end else if (per_raw_data_en && first) begin
         sh <= cfg_in;
      end
   end

   assign chan = chan_e'({v_cnt[0] ^ cfg.bayer[1], h_cnt[0] ^ cfg.bayer[0]});

   always_comb begin
      blk  = cfg.blk_r;
      gsel = cfg.g_r;
      case (chan)
         CH_GR:   begin blk = cfg.blk_gr; gsel = cfg.g_gr; end
         CH_GB:   begin blk = cfg.blk_gb; gsel = cfg.g_gb; end
         CH_B:    begin blk = cfg.blk_b;  gsel = cfg.g_b;  end
         default: begin blk = cfg.blk_r;  gsel = cfg.g_r;  end
      endcase
   end

   assign g_eff = cfg.gain_en ? gsel : UNITY;
   assign under = (per_raw_data < blk);

   // Gain travels with the pixel so a new frame's shadows cannot reach
   // pixels of the previous frame still in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         s1_sub   <= '0;
         s1_g     <= '0;
         s2_prod  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[2:1], per_raw_data_en};
         if (per_raw_data_en) begin
            s1_sub <= (per_raw_data > blk) ? per_raw_data - blk : '0;
            s1_g   <= g_eff;
         end
         if (vld_pipe[1])
            s2_prod <= P_W'(s1_sub) * P_W'(s1_g);
      end
   end

   assign rnd     = {1'b0, s2_prod} + HALF;
   assign shifted = rnd >> GAIN_FRAC;
   assign sat     = (shifted > MAXV) ? MAXV[BITS-1:0] : shifted[BITS-1:0];

   always_ff @(posedge clk) begin
      if (rst)
         post_raw_data <= '0;
      else if (vld_pipe[2])
         post_raw_data <= sat;
   end

   assign post_raw_data_en = vld_pipe[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         acc        <= '0;
         under_cnt  <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= per_raw_data_en && last;
         if (per_raw_data_en) begin
            if (last) begin
               under_cnt <= acc + CNT_W'(under);
               acc       <= '0;
            end else begin
               acc <= acc + CNT_W'(under);
            end
         end
      end
   end

endmodule

// File: tb/tb_isp_blc_norm.sv
// Directed bench for isp_blc_norm on a 4x2 frame; expected pixels and
// per-frame underflow counts are queued at issue time and checked by a monitor.
module tb_isp_blc_norm;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  black_r, black_gr, black_gb, black_b;
   logic [11:0] gain_r, gain_gr, gain_gb, gain_b;
   logic        gain_en;
   logic [1:0]  bayer;
   logic [7:0]  per_raw_data;
   logic        per_raw_data_en;
   logic [7:0]  post_raw_data;
   logic        post_raw_data_en;
   logic [3:0]  under_cnt;
   logic        frame_done;

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int und_q[$];

   isp_blc_norm #(.BITS(8), .WIDTH(4), .HEIGHT(2), .GAIN_W(12), .GAIN_FRAC(8)) dut (
      .clk              (clk),
      .rst              (rst),
      .black_r          (black_r),
      .black_gr         (black_gr),
      .black_gb         (black_gb),
      .black_b          (black_b),
      .gain_r           (gain_r),
      .gain_gr          (gain_gr),
      .gain_gb          (gain_gb),
      .gain_b           (gain_b),
      .gain_en          (gain_en),
      .bayer            (bayer),
      .per_raw_data     (per_raw_data),
      .per_raw_data_en  (per_raw_data_en),
      .post_raw_data    (post_raw_data),
      .post_raw_data_en (post_raw_data_en),
      .under_cnt        (under_cnt),
      .frame_done       (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Outputs change only on posedge, so sampling on negedge is race-free.
   always @(negedge clk) begin
      if (post_raw_data_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pixel: got %0d, expected no output", post_raw_data);
         end else begin
            chk("pixel", int'(post_raw_data), exp_q.pop_front());
         end
      end
      if (frame_done === 1'b1) begin
         if (und_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame_done: got under_cnt %0d, expected no pulse", under_cnt);
         end else begin
            chk("under_cnt", int'(under_cnt), und_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, expected finish within bound");
      $fatal(1, "timeout");
   end

   // e < 0 marks a pixel whose output must never appear.
   task automatic px(input int d, input int e);
      @(negedge clk);
      per_raw_data    = d[7:0];
      per_raw_data_en = 1'b1;
      if (e >= 0) exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         per_raw_data_en = 1'b0;
      end
   endtask

   task automatic set_black(input int r, input int gr, input int gb, input int b);
      black_r = r[7:0]; black_gr = gr[7:0]; black_gb = gb[7:0]; black_b = b[7:0];
   endtask

   task automatic set_gain(input int g);
      gain_r = g[11:0]; gain_gr = g[11:0]; gain_gb = g[11:0]; gain_b = g[11:0];
   endtask

   task automatic frame_const(input int d, input int e, input int und);
      und_q.push_back(und);
      for (int i = 0; i < 8; i++) px(d, e);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_post_en"},     int'(post_raw_data_en), 0);
      chk({tag, "_post_data"},   int'(post_raw_data),    0);
      chk({tag, "_under_cnt"},   int'(under_cnt),        0);
      chk({tag, "_frame_done"},  int'(frame_done),       0);
   endtask

   int e33[8] = '{84, 83, 84, 83, 82, 81, 82, 81};
   int e37[8] = '{60, 70, 60, 70, 80, 90, 80, 90};

   initial begin
      rst = 1'b1;
      per_raw_data = '0;
      per_raw_data_en = 1'b0;
      set_black(0, 0, 0, 0);
      set_gain(12'h100);
      gain_en = 1'b0;
      bayer   = 2'd0;
      repeat (2) @(negedge clk);
      chk_cleared("reset");
      rst = 1'b0;

      // RGGB, distinct black levels, unity gain, with a stream gap mid-frame
      set_black(16, 17, 18, 19);
      und_q.push_back(0);
      for (int i = 0; i < 8; i++) begin
         px(100, e33[i]);
         if (i == 2) idle(3);
      end
      idle(2);

      // Whole frame below black, then a frame with no underflow
      set_black(16, 16, 16, 16);
      frame_const(10, 0, 8);
      frame_const(200, 184, 0);
      idle(2);

      // Gain with rounding, then saturation
      gain_en = 1'b1;
      set_gain(12'h110);
      frame_const(255, 254, 0);
      set_gain(12'h200);
      frame_const(200, 255, 0);
      idle(2);

      // Black changed mid-frame only takes effect at the next frame
      gain_en = 1'b0;
      und_q.push_back(0);
      for (int i = 0; i < 8; i++) begin
         if (i == 3) set_black(40, 40, 40, 40);
         px(100, 84);
      end
      frame_const(100, 60, 0);
      idle(2);

      // Leave a nonzero under_cnt behind so the reset check below means something
      set_black(16, 16, 16, 16);
      frame_const(10, 0, 8);
      idle(4);

      // BGGR, reset mid-frame: pixels 3 and 4 are still in flight and vanish
      bayer = 2'd3;
      set_black(10, 20, 30, 40);
      for (int i = 0; i < 5; i++) px(100, (i < 3) ? e37[i] : -1);
      @(negedge clk);
      per_raw_data_en = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_cleared("midreset");
      rst = 1'b0;

      und_q.push_back(0);
      for (int i = 0; i < 8; i++) px(100, e37[i]);
      idle(8);

      chk("pixel_queue_drained", exp_q.size(), 0);
      chk("frame_queue_drained", und_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/isp_blc_norm.md
ISP_BLC_NORM -- requirements
Module: isp_blc_norm

Interface
REQ-001 SHALL have parameter BITS, default 8, meaning raw pixel width (8..16).
REQ-002 SHALL have parameter WIDTH, default 1936, meaning pixels per line.
REQ-003 SHALL have parameter HEIGHT, default 1088, meaning lines per frame.
REQ-004 SHALL have parameter GAIN_W, default 12, meaning per-channel gain width (unsigned fixed point).
REQ-005 SHALL have parameter GAIN_FRAC, default 8, meaning gain fractional bits (1.0 = 1<<GAIN_FRAC).
REQ-006 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have ports black_r, black_gr, black_gb, black_b, input, BITS bits each, per-channel black level.
REQ-009 SHALL have ports gain_r, gain_gr, gain_gb, gain_b, input, GAIN_W bits each, per-channel post-subtract gain.
REQ-010 SHALL have port gain_en, input, 1 bit; 0 forces unity gain.
REQ-011 SHALL have port bayer, input, 2 bits: 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR.
REQ-012 SHALL have ports per_raw_data (input, BITS) and per_raw_data_en (input, 1), the pixel stream and its qualifier.
REQ-013 SHALL have ports post_raw_data (output, BITS) and post_raw_data_en (output, 1), the corrected stream.
REQ-014 SHALL have port under_cnt, output, CNT_W = clog2(WIDTH*HEIGHT+1) bits, count of clipped-to-zero pixels in the last frame.
REQ-015 SHALL have port frame_done, output, 1 bit, one-cycle pulse when under_cnt updates.

Function
REQ-016 SHALL keep h_cnt (0..WIDTH-1) and v_cnt (0..HEIGHT-1), advancing only on per_raw_data_en; h wraps to 0 after WIDTH-1, v increments on h wrap and wraps to 0 after (HEIGHT-1, WIDTH-1).
REQ-017 SHALL select the channel as the RGGB position {v_cnt[0]^bayer[1], h_cnt[0]^bayer[0]}: 00 R, 01 Gr, 10 Gb, 11 B.
REQ-018 SHALL latch all black, gain, gain_en and bayer inputs into shadow registers on the enabled pixel at (0,0); that pixel and the rest of the frame use the latched values, and mid-frame input changes have no effect until the next frame.
REQ-019 Stage 1 SHALL register sub = in - black when in > black, else 0, flagging underflow when in < black (in == black gives 0 without a flag).
REQ-020 Stage 2 SHALL register prod = sub * g, with g = selected gain if gain_en else 1<<GAIN_FRAC, at full BITS+GAIN_W width.
REQ-021 Stage 3 SHALL register out = min((prod + 2^(GAIN_FRAC-1)) >> GAIN_FRAC, 2^BITS-1), i.e. round-half-up with saturation.
REQ-022 Latency SHALL be exactly 3 clocks from per_raw_data_en to post_raw_data_en, with the same latency when gain_en=0; the valid delay line is unconditional.
REQ-023 Stages SHALL register only on enabled pixels; post_raw_data holds its last value while post_raw_data_en=0.
REQ-024 SHALL accumulate underflow flags per frame; the count covering the last pixel (HEIGHT-1, WIDTH-1) is copied to under_cnt, frame_done pulses in that same cycle, and the accumulator restarts at 0 for the next frame.
REQ-025 under_cnt and frame_done SHALL align with the stage-1 register (1 clock after the last input pixel).
REQ-026 Gaps in per_raw_data_en of any length SHALL not disturb counters, shadows or pipeline contents.

Reset
REQ-027 On rst=1 SHALL clear h_cnt, v_cnt, all pipeline data and valids, the accumulator, under_cnt and frame_done to 0.
REQ-028 On rst=1 SHALL set shadows to black 0, gain 1<<GAIN_FRAC, gain_en 0, bayer RGGB.
REQ-029 Reset asserted mid-frame SHALL discard the in-flight pixels and make the next enabled pixel (0,0).

Structure
REQ-030 Bayer encodings, channel indices and the CNT_W function SHALL reside in shared package isp_pkg.
REQ-031 The h/v position counter SHALL be sub-module isp_raw_pos_cnt, reused by later ISP stages.

Verification (BITS=8, WIDTH=4, HEIGHT=2, GAIN_FRAC=8)
REQ-032 Reset: rst for 2 cycles -> all outputs 0; first en after reset is counted as (0,0).
REQ-033 RGGB, black r/gr/gb/b = 16/17/18/19, gain_en=0, constant input 100 -> outputs 84,83,84,83,82,81,82,81, valid 3 clocks after input.
REQ-034 Black 16 on all channels, input 10 on all 8 pixels -> out 0; under_cnt=8 with a one-cycle frame_done; next frame of input 200 -> under_cnt=0.
REQ-035 Gain: black 16, gain_en=1, gain 0x110, input 255 -> 254; gain 0x200, input 200 -> 255 (saturated).
REQ-036 Black changed from 16 to 40 at pixel 3 -> pixels 3..7 still use 16; the next frame uses 40.
REQ-037 bayer=BGGR with distinct black levels -> pixel (0,0) uses black_b and (1,1) uses black_r; rst asserted at pixel 5 -> outputs cleared and numbering restarts at (0,0).
